// File: rtl/ecc_pkg.sv
// ecc_pkg
//   Constants shared by the store-side encoder and the load-side DEC-TED
//   syndrome generator: the H_A / H_B check matrices, the 16-bit check-bit
//   field layout, the store-unit FSM encoding and the write-buffer payload.
//   Any change to the matrices must be mirrored by both encode and decode.
package ecc_pkg;

   localparam int DATA_W  = 32;
   localparam int PAR_W   = 16;
   localparam int BE_W    = DATA_W / 8;
   localparam int HA_ROWS = 7;
   localparam int HB_ROWS = 8;

   // Check-bit layout: [6:0] H_A rows, [14:7] H_B rows, [15] overall parity.
   localparam int PAR_A_LSB = 0;
   localparam int PAR_B_LSB = PAR_A_LSB + HA_ROWS;
   localparam int PAR_ALL   = PAR_B_LSB + HB_ROWS;

   // Row r selects the data bits that feed check bit r. Listed MSB row first.
   localparam logic [HA_ROWS-1:0][DATA_W-1:0] H_A = {
      32'hAAAA_5555,   // row 6
      32'hFC00_0000,   // row 5
      32'h03FF_F800,   // row 4
      32'h03FC_07F0,   // row 3
      32'hE3C3_C78E,   // row 2
      32'h9B33_366D,   // row 1
      32'h56AA_AD5B    // row 0
   };

   localparam logic [HB_ROWS-1:0][DATA_W-1:0] H_B = {
      32'h6969_9696,   // row 7
      32'h3C3C_C3C3,   // row 6
      32'h0FF0_F00F,   // row 5
      32'hF0F0_0F0F,   // row 4
      32'h8124_8124,   // row 3
      32'h4812_4812,   // row 2
      32'h2481_2481,   // row 1
      32'h1248_1248    // row 0
   };

   localparam logic [BE_W-1:0] BE_NONE = '0;
   localparam logic [BE_W-1:0] BE_FULL = '1;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_RD   = 3'd1,
      ST_CHK  = 3'd2,
      ST_MRG  = 3'd3,
      ST_WR   = 3'd4
   } st_state_e;

   // Per-entry store payload; the address lives in its own array because
   // its width is a parameter of the store unit.
   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic [BE_W-1:0]   be;
   } st_payload_t;

   // Byte-wise merge: new_d where be is set, old_d elsewhere.
   function automatic logic [DATA_W-1:0] merge_bytes(
      input logic [DATA_W-1:0] new_d,
      input logic [DATA_W-1:0] old_d,
      input logic [BE_W-1:0]   be
   );
      logic [DATA_W-1:0] m;
      m = old_d;
      for (int i = 0; i < BE_W; i++)
         if (be[i]) m[8*i +: 8] = new_d[8*i +: 8];
      return m;
   endfunction

endpackage

// File: rtl/ecc_encode.sv
// ecc_encode
//   Combinational DEC-TED check-bit generator.
//   data   : 32-bit word to protect
//   parity : 16 check bits; [6:0] H_A rows, [14:7] H_B rows, [15] even
//            parity over data and parity[14:0], so that the load decoder
//            sees all-zero syndromes on a clean word.
module ecc_encode
   import ecc_pkg::*;
(
   input  logic [DATA_W-1:0] data,
   output logic [PAR_W-1:0]  parity
);

   logic [PAR_ALL-1:0] rows;

   always_comb begin
      rows = '0;
      for (int r = 0; r < HA_ROWS; r++) rows[PAR_A_LSB + r] = ^(data & H_A[r]);
      for (int r = 0; r < HB_ROWS; r++) rows[PAR_B_LSB + r] = ^(data & H_B[r]);
   end

   // Overall bit covers the row checks too, making the whole codeword even.
   assign parity = {^{data, rows}, rows};

endmodule

// File: rtl/ecc_store_unit.sv
// ecc_store_unit
//   Store-side ECC path: buffers CPU stores in a DEPTH-entry FIFO, encodes
//   check bits and writes {data, parity} to the data cache. Partial stores
//   do read-modify-write through the load decoder, which also scrubs any
//   corrected bits in the rewritten word.
//
//   clk, rst_n               clock, async active-low reset
//   st_valid/st_ready        store handshake; st_addr/st_data/st_be payload
//   rd_en/rd_addr            RMW cache read (word returns next cycle)
//   corr_data/corr_triple    corrected word / uncorrectable flag from decoder
//   wr_en/wr_addr/wr_data/wr_parity   cache write port
//   ld_addr/ld_conflict      load-vs-pending-store address hazard
//   buf_empty                FIFO empty and FSM idle
//   err/err_addr             one-cycle pulse on uncorrectable RMW read,
//                            address held until the next err
module ecc_store_unit
   import ecc_pkg::*;
#(
   parameter int ADDR_W = 10,
   parameter int DEPTH  = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              st_valid,
   output logic              st_ready,
   input  logic [ADDR_W-1:0] st_addr,
   input  logic [DATA_W-1:0] st_data,
   input  logic [BE_W-1:0]   st_be,
   output logic              rd_en,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [DATA_W-1:0] corr_data,
   input  logic              corr_triple,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [DATA_W-1:0] wr_data,
   output logic [PAR_W-1:0]  wr_parity,
   input  logic [ADDR_W-1:0] ld_addr,
   output logic              ld_conflict,
   output logic              buf_empty,
   output logic              err,
   output logic [ADDR_W-1:0] err_addr
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   // ---------------- write buffer ----------------
   logic [ADDR_W-1:0] fifo_addr [DEPTH];
   st_payload_t       fifo_pay  [DEPTH];
   logic [PTR_W-1:0]  rd_ptr, wr_ptr;
   logic [CNT_W-1:0]  count;
   logic              push, pop;

   logic [ADDR_W-1:0] head_addr;
   st_payload_t       head_pay;

   assign st_ready  = (count != CNT_W'(DEPTH));
   assign push      = st_valid && st_ready;
   assign head_addr = fifo_addr[rd_ptr];
   assign head_pay  = fifo_pay[rd_ptr];

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_addr[wr_ptr] <= st_addr;
         fifo_pay[wr_ptr]  <= '{data: st_data, be: st_be};
      end
   end

   // DEPTH is a power of two, so the pointers wrap naturally.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // ---------------- dequeue FSM ----------------
   st_state_e         state_q, state_d;
   logic              latch;
   logic [ADDR_W-1:0] w_addr;
   logic [DATA_W-1:0] w_data;
   logic [BE_W-1:0]   w_be;
   logic [DATA_W-1:0] wr_data_q;
   logic [PAR_W-1:0]  wr_par_q;
   logic              err_q;
   logic [ADDR_W-1:0] err_addr_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   // The head entry stays in the FIFO until its write (or error) retires,
   // so it keeps matching ld_addr for the whole RMW.
   always_comb begin
      state_d = state_q;
      pop     = 1'b0;
      latch   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (count != '0) begin
               if (head_pay.be == BE_NONE) begin
                  pop = 1'b1;
               end else begin
                  latch   = 1'b1;
                  state_d = (head_pay.be == BE_FULL) ? ST_WR : ST_RD;
               end
            end
         end
         ST_RD:   state_d = ST_CHK;
         ST_CHK: begin
            if (corr_triple) begin
               pop     = 1'b1;
               state_d = ST_IDLE;
            end else begin
               state_d = ST_MRG;
            end
         end
         ST_MRG:  state_d = ST_WR;
         ST_WR: begin
            pop     = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // One encoder: full-word stores encode straight from the head in IDLE,
   // RMW stores encode the merged word in MRG.
   logic [DATA_W-1:0] enc_in;
   logic [PAR_W-1:0]  enc_par;

   assign enc_in = (state_q == ST_MRG) ? w_data : head_pay.data;

   ecc_encode u_enc (
      .data   (enc_in),
      .parity (enc_par)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         w_addr     <= '0;
         w_data     <= '0;
         w_be       <= '0;
         wr_data_q  <= '0;
         wr_par_q   <= '0;
         err_q      <= 1'b0;
         err_addr_q <= '0;
      end else begin
         err_q <= (state_q == ST_CHK) && corr_triple;
         if ((state_q == ST_CHK) && corr_triple) err_addr_q <= w_addr;

         if (latch) begin
            w_addr <= head_addr;
            w_data <= head_pay.data;
            w_be   <= head_pay.be;
            if (head_pay.be == BE_FULL) begin
               wr_data_q <= head_pay.data;
               wr_par_q  <= enc_par;
            end
         end

         // Merge in place; the old word is already corrected by the decoder.
         if ((state_q == ST_CHK) && !corr_triple)
            w_data <= merge_bytes(w_data, corr_data, w_be);

         if (state_q == ST_MRG) begin
            wr_data_q <= w_data;
            wr_par_q  <= enc_par;
         end
      end
   end

   // ---------------- load hazard ----------------
   always_comb begin
      logic [PTR_W-1:0] off;
      ld_conflict = (state_q != ST_IDLE) && (w_addr == ld_addr);
      for (int i = 0; i < DEPTH; i++) begin
         off = PTR_W'(i) - rd_ptr;
         if (({1'b0, off} < count) && (fifo_addr[i] == ld_addr))
            ld_conflict = 1'b1;
      end
   end

   // ---------------- outputs ----------------
   assign rd_en     = (state_q == ST_RD);
   assign rd_addr   = w_addr;
   assign wr_en     = (state_q == ST_WR);
   assign wr_addr   = w_addr;
   assign wr_data   = wr_data_q;
   assign wr_parity = wr_par_q;
   assign err       = err_q;
   assign err_addr  = err_addr_q;
   assign buf_empty = (count == '0) && (state_q == ST_IDLE);

endmodule

// File: tb/tb_ecc_store_unit.sv
module tb_ecc_store_unit;
   import ecc_pkg::*;

   localparam int ADDR_W = 10;
   localparam int DEPTH  = 4;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              st_valid;
   logic              st_ready;
   logic [ADDR_W-1:0] st_addr;
   logic [31:0]       st_data;
   logic [3:0]        st_be;
   logic              rd_en;
   logic [ADDR_W-1:0] rd_addr;
   logic [31:0]       corr_data;
   logic              corr_triple;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [31:0]       wr_data;
   logic [15:0]       wr_parity;
   logic [ADDR_W-1:0] ld_addr;
   logic              ld_conflict;
   logic              buf_empty;
   logic              err;
   logic [ADDR_W-1:0] err_addr;

   ecc_store_unit #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n),
      .st_valid(st_valid), .st_ready(st_ready),
      .st_addr(st_addr), .st_data(st_data), .st_be(st_be),
      .rd_en(rd_en), .rd_addr(rd_addr),
      .corr_data(corr_data), .corr_triple(corr_triple),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_parity(wr_parity),
      .ld_addr(ld_addr), .ld_conflict(ld_conflict),
      .buf_empty(buf_empty), .err(err), .err_addr(err_addr)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got=%0h exp=%0h", name, act, exp);
      end
   endtask

   // Independent syndrome: walk each data bit and toggle every row it feeds.
   function automatic logic [15:0] syndrome(input logic [31:0] d, input logic [15:0] p);
      logic [15:0] s;
      s = p;
      for (int j = 0; j < 32; j++) begin
         if (d[j]) begin
            for (int r = 0; r < 7; r++) if (H_A[r][j]) s[r]     = ~s[r];
            for (int r = 0; r < 8; r++) if (H_B[r][j]) s[7 + r] = ~s[7 + r];
         end
      end
      s[15] = ^{d, p};
      return s;
   endfunction

   // ---------------- scoreboard ----------------
   typedef struct {
      logic              is_err;
      logic [ADDR_W-1:0] addr;
      logic [31:0]       data;
   } exp_t;
   exp_t sb[$];

   task automatic expect_wr(input logic [ADDR_W-1:0] a, input logic [31:0] d);
      exp_t e;
      e.is_err = 1'b0; e.addr = a; e.data = d;
      sb.push_back(e);
   endtask

   task automatic expect_err(input logic [ADDR_W-1:0] a);
      exp_t e;
      e.is_err = 1'b1; e.addr = a; e.data = '0;
      sb.push_back(e);
   endtask

   // Cache model: corrected word returned by the load decoder.
   logic [31:0] cache_mem [0:1023];
   logic        cache_bad [0:1023];

   always @(negedge clk) begin
      logic [ADDR_W-1:0] a;
      if (rst_n && rd_en) begin
         a = rd_addr;
         @(posedge clk);
         #1;
         corr_data   = cache_mem[a];
         corr_triple = cache_bad[a];
      end
   end

   int n_wr = 0, n_rd = 0, n_err = 0;
   int last_wr_cyc = 0, last_rd_cyc = 0;

   always @(negedge clk) begin
      exp_t e;
      if (rst_n) begin
         if (rd_en || wr_en) chk("rd_wr_exclusive", {63'd0, rd_en & wr_en}, 64'd0);
         if (rd_en) begin
            n_rd++;
            last_rd_cyc = cyc;
         end
         if (wr_en) begin
            n_wr++;
            last_wr_cyc = cyc;
            if (sb.size() == 0) begin
               chk("unexpected_wr_addr", {54'd0, wr_addr}, 64'hFFFF);
            end else begin
               e = sb.pop_front();
               chk("wr_kind", {63'd0, e.is_err}, 64'd0);
               chk("wr_addr", {54'd0, wr_addr}, {54'd0, e.addr});
               chk("wr_data", {32'd0, wr_data}, {32'd0, e.data});
               chk("wr_syndrome", {48'd0, syndrome(wr_data, wr_parity)}, 64'd0);
            end
         end
         if (err) begin
            n_err++;
            if (sb.size() == 0) begin
               chk("unexpected_err_addr", {54'd0, err_addr}, 64'hFFFF);
            end else begin
               e = sb.pop_front();
               chk("err_kind", {63'd0, e.is_err}, 64'd1);
               chk("err_addr", {54'd0, err_addr}, {54'd0, e.addr});
            end
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic push(input logic [ADDR_W-1:0] a, input logic [31:0] d,
                       input logic [3:0] be, output int acc);
      int w;
      w = 0;
      acc = 0;
      @(negedge clk);
      st_valid = 1'b1; st_addr = a; st_data = d; st_be = be;
      while (!st_ready && w < 100) begin
         @(negedge clk);
         w++;
      end
      if (!st_ready) begin
         chk("push_timeout", {63'd0, st_ready}, 64'd1);
         st_valid = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      acc = cyc;
      st_valid = 1'b0;
   endtask

   task automatic wait_done(input string name, output int early);
      int w;
      w = 0;
      early = 0;
      do begin
         @(negedge clk);
         if (buf_empty && sb.size() != 0 && !err) early++;
         w++;
      end while ((sb.size() != 0 || !buf_empty) && w < 300);
      chk({"drain_", name}, {62'd0, (sb.size() == 0), buf_empty}, 64'd3);
   endtask

   typedef struct {
      logic [ADDR_W-1:0] addr;
      logic [31:0]       data;
      logic [3:0]        be;
      logic [31:0]       old;
      logic              bad;
      logic              exp_err;
      logic              exp_wr;
      logic              exp_rd;
      logic [31:0]       exp_data;
   } vec_t;

   vec_t tbl[8];

   initial begin
      int acc, acc2, early, n0, r0, e0, w;
      logic [31:0] bd [5];

      #200000;
      $display("FAIL watchdog: got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int acc, acc2, early, n0, r0, e0, w;

      rst_n = 1'b0; st_valid = 1'b0; st_addr = '0; st_data = '0; st_be = '0;
      corr_data = '0; corr_triple = 1'b0; ld_addr = '0;
      for (int i = 0; i < 1024; i++) begin
         cache_mem[i] = 32'h0;
         cache_bad[i] = 1'b0;
      end

      tbl[0] = '{10'h005, 32'hDEADBEEF, 4'hF,    32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 32'hDEADBEEF};
      tbl[1] = '{10'h010, 32'h0000AB00, 4'b0010, 32'h11223344, 1'b0, 1'b0, 1'b1, 1'b1, 32'h1122AB44};
      tbl[2] = '{10'h3FF, 32'h12345678, 4'b0001, 32'h0,        1'b1, 1'b1, 1'b0, 1'b1, 32'h0};
      tbl[3] = '{10'h020, 32'hAABBCCDD, 4'b1001, 32'h00000000, 1'b0, 1'b0, 1'b1, 1'b1, 32'hAA0000DD};
      tbl[4] = '{10'h021, 32'hFFFFFFFF, 4'b0110, 32'h12345678, 1'b0, 1'b0, 1'b1, 1'b1, 32'h12FFFF78};
      tbl[5] = '{10'h022, 32'h55AA55AA, 4'b0000, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
      tbl[6] = '{10'h000, 32'h00000000, 4'hF,    32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 32'h0};
      tbl[7] = '{10'h3FE, 32'h0F0F0F0F, 4'b0100, 32'hA5A5A5A5, 1'b0, 1'b0, 1'b1, 1'b1, 32'hA50FA5A5};

      // Reset state
      #1;
      chk("rst_rd_wr_err", {61'd0, rd_en, wr_en, err}, 64'd0);
      chk("rst_ready_empty", {62'd0, st_ready, buf_empty}, 64'd3);
      chk("rst_ld_conflict", {63'd0, ld_conflict}, 64'd0);
      chk("rst_addrs", {34'd0, rd_addr, wr_addr, err_addr}, 64'd0);
      chk("rst_wr_data_par", {16'd0, wr_data, wr_parity}, 64'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Table-driven single stores
      for (int k = 0; k < 8; k++) begin
         cache_mem[tbl[k].addr] = tbl[k].old;
         cache_bad[tbl[k].addr] = tbl[k].bad;
         n0 = n_wr; r0 = n_rd; e0 = n_err;
         if (tbl[k].exp_wr)  expect_wr(tbl[k].addr, tbl[k].exp_data);
         if (tbl[k].exp_err) expect_err(tbl[k].addr);
         push(tbl[k].addr, tbl[k].data, tbl[k].be, acc);
         wait_done($sformatf("vec%0d", k), early);
         repeat (2) @(negedge clk);
         chk($sformatf("vec%0d_nwr", k), 64'(n_wr - n0), {63'd0, tbl[k].exp_wr});
         chk($sformatf("vec%0d_nrd", k), 64'(n_rd - r0), {63'd0, tbl[k].exp_rd});
         chk($sformatf("vec%0d_nerr", k), 64'(n_err - e0), {63'd0, tbl[k].exp_err});
         cache_bad[tbl[k].addr] = 1'b0;
      end
      chk("err_addr_held", {54'd0, err_addr}, 64'h3FF);

      // Full-word latency: wr_en one cycle after the cycle following accept
      expect_wr(10'h005, 32'hCAFEBABE);
      push(10'h005, 32'hCAFEBABE, 4'hF, acc);
      wait_done("lat_full", early);
      chk("lat_full_wr", 64'(last_wr_cyc - acc), 64'd1);

      // Partial latency: rd_en at +1, wr_en at +4 relative to the same point
      cache_mem[10'h010] = 32'h11223344;
      expect_wr(10'h010, 32'h1122AB44);
      push(10'h010, 32'h0000AB00, 4'b0010, acc);
      wait_done("lat_part", early);
      chk("lat_part_rd", 64'(last_rd_cyc - acc), 64'd1);
      chk("lat_part_wr", 64'(last_wr_cyc - acc), 64'd4);

      // Two full-word stores back to back: writes two cycles apart
      expect_wr(10'h050, 32'h00000050);
      expect_wr(10'h051, 32'h00000051);
      push(10'h050, 32'h00000050, 4'hF, acc);
      push(10'h051, 32'h00000051, 4'hF, acc2);
      n0 = last_wr_cyc;
      wait_done("thru", early);
      chk("thru_wr_spacing", 64'(last_wr_cyc - acc), 64'd3);

      // Uncorrectable RMW followed by a normal store
      cache_bad[10'h3FF] = 1'b1;
      n0 = n_wr; e0 = n_err;
      expect_err(10'h3FF);
      expect_wr(10'h040, 32'hCAFEF00D);
      push(10'h3FF, 32'h000000AA, 4'b0001, acc);
      push(10'h040, 32'hCAFEF00D, 4'hF, acc2);
      wait_done("triple", early);
      repeat (2) @(negedge clk);
      chk("triple_nerr", 64'(n_err - e0), 64'd1);
      chk("triple_nwr", 64'(n_wr - n0), 64'd1);
      chk("triple_err_addr", {54'd0, err_addr}, 64'h3FF);
      cache_bad[10'h3FF] = 1'b0;

      // Burst of 5 behind an RMW head: fills to DEPTH, then drains in order
      cache_mem[10'h030] = 32'h01020304;
      expect_wr(10'h030, 32'h010203EE);
      for (int i = 1; i < 5; i++) expect_wr(10'(10'h030 + i), 32'h1000_0000 + i);
      push(10'h030, 32'h000000EE, 4'b0001, acc);
      for (int i = 1; i < 4; i++) push(10'(10'h030 + i), 32'h1000_0000 + i, 4'hF, acc);
      chk("burst_full_ready", {63'd0, st_ready}, 64'd0);
      chk("burst_full_empty", {63'd0, buf_empty}, 64'd0);
      push(10'h034, 32'h1000_0004, 4'hF, acc);
      wait_done("burst", early);
      chk("burst_early_empty", 64'(early), 64'd0);

      // Load hazard against the third buffered store
      cache_mem[10'h100] = 32'h0;
      expect_wr(10'h100, 32'h00000077);
      expect_wr(10'h101, 32'h00000101);
      expect_wr(10'h102, 32'h00000102);
      ld_addr = 10'h102;
      push(10'h100, 32'h00000077, 4'b0001, acc);
      push(10'h101, 32'h00000101, 4'hF, acc);
      push(10'h102, 32'h00000102, 4'hF, acc);
      chk("ldc_buffered", {63'd0, ld_conflict}, 64'd1);
      w = 0;
      do begin
         @(negedge clk);
         w++;
      end while (!(wr_en && wr_addr == 10'h102) && w < 100);
      chk("ldc_during_wr", {63'd0, ld_conflict}, 64'd1);
      @(negedge clk);
      chk("ldc_after_wr", {63'd0, ld_conflict}, 64'd0);
      wait_done("ldc", early);
      ld_addr = 10'h3AB;

      // Reset in the middle of an RMW: the store is abandoned
      cache_mem[10'h200] = 32'h89ABCDEF;
      n0 = n_wr;
      ld_addr = 10'h200;
      push(10'h200, 32'h00001234, 4'b0011, acc);
      w = 0;
      while (!rd_en && w < 20) begin
         @(negedge clk);
         w++;
      end
      @(negedge clk);   // CHK cycle
      rst_n = 1'b0;
      #1;
      chk("midrst_ready_empty", {62'd0, st_ready, buf_empty}, 64'd3);
      chk("midrst_rd_wr_err", {61'd0, rd_en, wr_en, err}, 64'd0);
      chk("midrst_ldc", {63'd0, ld_conflict}, 64'd0);
      chk("midrst_err_addr", {54'd0, err_addr}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      chk("midrst_no_wr", 64'(n_wr - n0), 64'd0);
      chk("midrst_sb_empty", 64'(sb.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
